// File: rtl/rom_rd_responder_if.sv
// rtl/rom_rd_responder_if.sv - cache-side and SDRAM-side signal bundle for the ROM read responder
interface rom_rd_responder_if #(
    parameter int ADDR_W = 17,
    parameter int MEM_AW = 16
);
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              rom_valid;
    logic              invalidate;
    logic              mem_req;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_data;

    modport slave (
        input  rom_req, rom_addr, invalidate, mem_ack, mem_data,
        output rom_data, rom_valid, mem_req, mem_addr
    );

    modport master (
        output rom_req, rom_addr, invalidate, mem_ack, mem_data,
        input  rom_data, rom_valid, mem_req, mem_addr
    );
endinterface

// File: rtl/rom_rd_responder.sv
// rtl/rom_rd_responder.sv - ROM read responder with a one-pair line buffer in front of the SDRAM read port
module rom_rd_responder #(
    parameter int ADDR_W = 17,
    parameter int MEM_AW = 16
) (
    input  logic               clk,
    input  logic               reset,
    rom_rd_responder_if.slave  bus
);
    typedef enum logic {IDLE, FETCH} state_t;

    state_t            state, state_n;
    logic              mem_req_r, mem_req_n;
    logic [MEM_AW-1:0] mem_addr_r, mem_addr_n;
    logic [31:0]       buf_data, buf_data_n;
    logic [MEM_AW-1:0] buf_tag, buf_tag_n;
    logic              buf_valid, buf_valid_n;
    logic              ready_r, ready_n;
    logic [ADDR_W-1:0] served_addr, served_n;
    logic [ADDR_W-1:0] req_addr, req_addr_n;
    logic              discard, discard_n;

    logic addr_match, new_req, hit;

    assign addr_match = (bus.rom_addr == served_addr);
    assign new_req    = bus.rom_req && !(ready_r && addr_match);
    assign hit        = buf_valid && (bus.rom_addr[ADDR_W-1:1] == buf_tag);

    assign bus.rom_valid = ready_r && bus.rom_req && addr_match;
    assign bus.rom_data  = served_addr[0] ? buf_data[31:16] : buf_data[15:0];
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_addr  = mem_addr_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= '0;
            buf_data    <= '0;
            buf_tag     <= '0;
            buf_valid   <= 1'b0;
            ready_r     <= 1'b0;
            served_addr <= '0;
            req_addr    <= '0;
            discard     <= 1'b0;
        end else begin
            state       <= state_n;
            mem_req_r   <= mem_req_n;
            mem_addr_r  <= mem_addr_n;
            buf_data    <= buf_data_n;
            buf_tag     <= buf_tag_n;
            buf_valid   <= buf_valid_n;
            ready_r     <= ready_n;
            served_addr <= served_n;
            req_addr    <= req_addr_n;
            discard     <= discard_n;
        end
    end

    always_comb begin
        state_n     = state;
        mem_req_n   = mem_req_r;
        mem_addr_n  = mem_addr_r;
        buf_data_n  = buf_data;
        buf_tag_n   = buf_tag;
        buf_valid_n = buf_valid;
        ready_n     = ready_r;
        served_n    = served_addr;
        req_addr_n  = req_addr;
        discard_n   = discard;
        case (state)
            IDLE: begin
                if (bus.invalidate) begin
                    buf_valid_n = 1'b0;
                    ready_n     = 1'b0;
                end
                // An invalidate in the same cycle wins over a buffer hit.
                if (new_req) begin
                    if (hit && !bus.invalidate) begin
                        served_n = bus.rom_addr;
                        ready_n  = 1'b1;
                    end else begin
                        ready_n    = 1'b0;
                        mem_req_n  = 1'b1;
                        mem_addr_n = bus.rom_addr[ADDR_W-1:1];
                        req_addr_n = bus.rom_addr;
                        state_n    = FETCH;
                    end
                end else if (!bus.rom_req) begin
                    ready_n = 1'b0;
                end
            end
            FETCH: begin
                if (bus.invalidate) discard_n = 1'b1;
                // The fetch always completes; stale addresses simply fail the valid compare.
                if (bus.mem_ack) begin
                    mem_req_n   = 1'b0;
                    buf_data_n  = bus.mem_data;
                    buf_tag_n   = mem_addr_r;
                    buf_valid_n = !(discard || bus.invalidate);
                    served_n    = req_addr;
                    ready_n     = 1'b1;
                    discard_n   = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rom_rd_responder.sv
// tb/tb_rom_rd_responder.sv - scoreboard bench for rom_rd_responder
module tb_rom_rd_responder;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    logic [15:0] exp_data_q[$];
    logic [15:0] exp_mem_q[$];

    rom_rd_responder_if #(.ADDR_W(17), .MEM_AW(16)) bus ();

    rom_rd_responder #(.ADDR_W(17), .MEM_AW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_mem_req();
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_req === 1'b1) return;
            cyc(1);
        end
        chk("mem_req_timeout", 32'd0, 32'd1);
    endtask

    task automatic ack(input logic [31:0] d);
        bus.mem_data = d;
        bus.mem_ack  = 1'b1;
        cyc(1);
        bus.mem_ack  = 1'b0;
        bus.mem_data = '0;
    endtask

    task automatic chk_neg(input string name, input logic act_sel, input logic exp);
        @(negedge clk);
        chk(name, {31'd0, act_sel ? bus.mem_req : bus.rom_valid}, {31'd0, exp});
    endtask

    // Monitor: every rising rom_valid / mem_req must match the next queued expectation.
    logic prev_valid = 1'b0;
    logic prev_req   = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.rom_valid === 1'b1 && !prev_valid) begin
                if (exp_data_q.size() == 0) chk("unexpected_rom_valid", {16'd0, bus.rom_data}, 32'hFFFF_FFFF);
                else chk("rom_data", {16'd0, bus.rom_data}, {16'd0, exp_data_q.pop_front()});
            end
            if (bus.mem_req === 1'b1 && !prev_req) begin
                if (exp_mem_q.size() == 0) chk("unexpected_mem_req", {16'd0, bus.mem_addr}, 32'hFFFF_FFFF);
                else chk("mem_addr", {16'd0, bus.mem_addr}, {16'd0, exp_mem_q.pop_front()});
            end
        end
        prev_valid = (bus.rom_valid === 1'b1);
        prev_req   = (bus.mem_req === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.rom_req = 1'b0; bus.rom_addr = '0; bus.invalidate = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_data = '0;
        cyc(3);
        reset = 1'b0;
        chk_neg("reset_rom_valid", 1'b0, 1'b0);
        chk("reset_mem_req", {31'd0, bus.mem_req}, 32'd0);
        mon_en = 1'b1;
        cyc(1);

        // Cold miss
        exp_mem_q.push_back(16'h0008); exp_data_q.push_back(16'h1234);
        bus.rom_req = 1'b1; bus.rom_addr = 17'h00010;
        wait_mem_req();
        chk_neg("cold_mem_req_held", 1'b1, 1'b1);
        cyc(3);
        chk("cold_mem_addr_held", {16'd0, bus.mem_addr}, 32'h0008);
        ack(32'hBEEF1234);
        chk_neg("cold_valid_latency", 1'b0, 1'b1);
        cyc(1);

        // Pair hit
        exp_data_q.push_back(16'hBEEF);
        bus.rom_addr = 17'h00011;
        chk_neg("hit_valid_drop", 1'b0, 1'b0);
        cyc(1);
        chk_neg("hit_valid_rise", 1'b0, 1'b1);
        chk("hit_no_mem_req", {31'd0, bus.mem_req}, 32'd0);
        cyc(1);

        // Sequential miss
        exp_mem_q.push_back(16'h0009); exp_data_q.push_back(16'h7788);
        bus.rom_addr = 17'h00012;
        wait_mem_req();
        cyc(2);
        ack(32'h55667788);
        chk_neg("seq_valid", 1'b0, 1'b1);
        cyc(1);

        // Invalidate in IDLE, then the odd word of the same pair must refetch
        bus.invalidate = 1'b1;
        cyc(1);
        bus.invalidate = 1'b0;
        exp_mem_q.push_back(16'h0009); exp_data_q.push_back(16'h1122);
        bus.rom_addr = 17'h00013;
        wait_mem_req();
        cyc(1);
        ack(32'h11223344);
        chk_neg("inv_idle_valid", 1'b0, 1'b1);
        cyc(1);

        // Invalidate during FETCH: data delivered, not retained
        exp_mem_q.push_back(16'h0010); exp_data_q.push_back(16'h0001);
        bus.rom_addr = 17'h00020;
        wait_mem_req();
        bus.invalidate = 1'b1;
        cyc(1);
        bus.invalidate = 1'b0;
        cyc(1);
        ack(32'hCAFE0001);
        chk_neg("inv_fetch_valid", 1'b0, 1'b1);
        cyc(1);
        bus.rom_req = 1'b0;
        cyc(1);
        exp_mem_q.push_back(16'h0010); exp_data_q.push_back(16'h0002);
        bus.rom_req = 1'b1;
        wait_mem_req();
        ack(32'hCAFE0002);
        cyc(1);
        exp_data_q.push_back(16'hCAFE);
        bus.rom_addr = 17'h00021;
        cyc(1);
        chk_neg("refill_hit", 1'b0, 1'b1);
        cyc(1);

        // Invalidate coincident with mem_ack
        exp_mem_q.push_back(16'h0018); exp_data_q.push_back(16'h0042);
        bus.rom_addr = 17'h00030;
        wait_mem_req();
        bus.invalidate = 1'b1;
        ack(32'h99990042);
        bus.invalidate = 1'b0;
        chk_neg("inv_ack_valid", 1'b0, 1'b1);
        cyc(1);
        exp_mem_q.push_back(16'h0018); exp_data_q.push_back(16'h7777);
        bus.rom_addr = 17'h00031;
        wait_mem_req();
        ack(32'h77770000);
        cyc(1);

        // Withdrawn request
        exp_mem_q.push_back(16'h0020);
        bus.rom_addr = 17'h00040;
        wait_mem_req();
        bus.rom_req = 1'b0;
        cyc(2);
        ack(32'hDEAD5A5A);
        chk_neg("withdrawn_no_valid", 1'b0, 1'b0);
        cyc(2);
        exp_data_q.push_back(16'hDEAD);
        bus.rom_req = 1'b1; bus.rom_addr = 17'h00041;
        cyc(1);
        chk_neg("withdrawn_then_hit", 1'b0, 1'b1);
        chk("withdrawn_hit_no_mem", {31'd0, bus.mem_req}, 32'd0);
        cyc(1);

        // Reset mid-FETCH with a stray ack afterwards
        exp_mem_q.push_back(16'h0028);
        bus.rom_addr = 17'h00050;
        wait_mem_req();
        reset = 1'b1; bus.rom_req = 1'b0;
        cyc(1);
        reset = 1'b0;
        chk_neg("reset_fetch_mem_req", 1'b1, 1'b0);
        cyc(2);
        ack(32'h12345678);
        chk_neg("stray_ack_no_valid", 1'b0, 1'b0);
        chk("stray_ack_no_mem_req", {31'd0, bus.mem_req}, 32'd0);
        cyc(1);
        exp_mem_q.push_back(16'h0028); exp_data_q.push_back(16'hABCD);
        bus.rom_req = 1'b1; bus.rom_addr = 17'h00051;
        wait_mem_req();
        ack(32'hABCD0000);
        chk_neg("post_reset_miss_valid", 1'b0, 1'b1);
        cyc(2);

        chk("data_queue_drained", exp_data_q.size(), 32'd0);
        chk("mem_queue_drained", exp_mem_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
